util_reset_gen: RTL and testbench

Reset sequencer that drives the active-low reset of a downstream clock domain and waits for that domain to report synchronized release. It sits on the initiating side of a domain reset: its output feeds the target domain's reset synchronizer, and the synchronizer's released reset comes back as the done signal. Software or control logic requests a domain reset with a four-phase req/ack handshake. The block stretches the reset to a guaranteed minimum width and acknowledges only after the target domain is out of reset.

---
 rtl/util_reset_gen_pkg.sv | 22 ++
 rtl/util_reset_gen_if.sv | 27 ++
 rtl/util_reset_gen_sync.sv | 19 +
 rtl/util_reset_gen.sv | 130 +++++++++++++
 tb/tb_util_reset_gen.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/util_reset_gen_pkg.sv
// Shared types and helpers for the domain reset sequencer.
package util_reset_gen_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ASSERT       = 2'd1,
        WAIT_RELEASE = 2'd2,
        ACK          = 2'd3
    } state_e;

    localparam int unsigned HOLD_MIN = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Lower bound on the reset hold width; checked at elaboration by the top.
    function automatic bit hold_cycles_ok(input int unsigned hold);
        return hold >= HOLD_MIN;
    endfunction

endpackage

// File: rtl/util_reset_gen_if.sv
// Request/ack handshake and target-domain reset signals of util_reset_gen.
interface util_reset_gen_if;
    logic req_i;
    logic ack_o;
    logic busy_o;
    logic domain_reset_q_o;
    logic domain_done_i;
    logic err_o;

    modport master (
        output req_i,
        output domain_done_i,
        input  ack_o,
        input  busy_o,
        input  domain_reset_q_o,
        input  err_o
    );

    modport slave (
        input  req_i,
        input  domain_done_i,
        output ack_o,
        output busy_o,
        output domain_reset_q_o,
        output err_o
    );
endinterface

// File: rtl/util_reset_gen_sync.sv
// Two-flop synchronizer with asynchronous active-low reset.
module util_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end
endmodule

// File: rtl/util_reset_gen.sv
// Domain reset sequencer: stretches the target reset, waits for synced release, then acks.
// Optional WAIT_RELEASE timeout with sticky err_o enabled by UTIL_RESET_GEN_TIMEOUT_EN.
module util_reset_gen
    import util_reset_gen_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic           clk_i,
    input  logic           reset_i,
    util_reset_gen_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    if (!hold_cycles_ok(HOLD_CYCLES)) begin : g_hold_chk
        $error("util_reset_gen: HOLD_CYCLES must be at least %0d", HOLD_MIN);
    end

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             por, por_n;
    logic             done_s;
    logic             rst_q, ack, busy;

    util_sync u_done_sync (
        .clk_i  (clk_i),
        .rst_ni (~reset_i),
        .d_i    (bus.domain_done_i),
        .q_o    (done_s)
    );

`ifdef UTIL_RESET_GEN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic err, err_n;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        por_n   = por;
`ifdef UTIL_RESET_GEN_TIMEOUT_EN
        err_n   = err;
`endif
        case (state)
            IDLE: begin
                if (bus.req_i) begin
                    state_n = ASSERT;
                    cnt_n   = '0;
                    por_n   = 1'b0;
`ifdef UTIL_RESET_GEN_TIMEOUT_EN
                    err_n   = 1'b0;
`endif
                end
            end
            ASSERT: begin
                // Counter saturates at expiry until a stale done has cleared.
                if (cnt != HOLD_LAST) begin
                    cnt_n = cnt + CNT_W'(1);
                end else if (!done_s) begin
                    state_n = WAIT_RELEASE;
                    cnt_n   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (done_s) begin
                    state_n = por ? IDLE : ACK;
                    por_n   = 1'b0;
                    cnt_n   = '0;
                end
`ifdef UTIL_RESET_GEN_TIMEOUT_EN
                else if (cnt == TIMEOUT_LAST) begin
                    state_n = por ? IDLE : ACK;
                    por_n   = 1'b0;
                    err_n   = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
`endif
            end
            ACK: begin
                if (!bus.req_i) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ASSERT;
            cnt   <= '0;
            por   <= 1'b1;
            rst_q <= 1'b0;
            ack   <= 1'b0;
            busy  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            por   <= por_n;
            rst_q <= (state_n != ASSERT);
            ack   <= (state_n == ACK);
            busy  <= (state_n == ASSERT) || (state_n == WAIT_RELEASE);
        end
    end

`ifdef UTIL_RESET_GEN_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err <= 1'b0;
        end else begin
            err <= err_n;
        end
    end
    assign bus.err_o = err;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.domain_reset_q_o = rst_q;
    assign bus.ack_o            = ack;
    assign bus.busy_o           = busy;
endmodule

// File: tb/tb_util_reset_gen.sv
// Randomized event-timing bench for util_reset_gen (default build, timeout feature off).
module tb_util_reset_gen;
    localparam int H = 16;

    logic clk = 1'b0;
    logic reset_i;
    int   n_checks = 0;
    int   n_errors = 0;

    util_reset_gen_if bus ();

    util_reset_gen #(
        .HOLD_CYCLES    (H),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Reset is held on entry with done low; cycle 0 is the first cycle after release.
    // Expected: reset output rises after H cycles, idle 3 cycles after done rises, no ack.
    task automatic run_por(input int p);
        int rise = -1, busy_fall = -1, ack_seen = 0;
        check_eq("rst_q_in_reset", int'(bus.domain_reset_q_o), 0);
        check_eq("busy_in_reset",  int'(bus.busy_o), 1);
        check_eq("ack_in_reset",   int'(bus.ack_o), 0);
        check_eq("err_in_reset",   int'(bus.err_o), 0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        for (int k = 0; k <= p + 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            bus.domain_done_i = (k >= p);
            @(negedge clk);
            if (bus.domain_reset_q_o && rise < 0) rise = k;
            if (!bus.busy_o && busy_fall < 0) busy_fall = k;
            if (bus.ack_o) ack_seen = 1;
        end
        check_eq("por_rst_width", rise, H);
        check_eq("por_idle_time", busy_fall, p + 3);
        check_eq("por_no_ack", ack_seen, 0);
    endtask

    // Request from IDLE; done stays high until cycle d0, rises again lat cycles after release.
    task automatic run_request(input int d0, input int lat, input bit early, input int extra);
        int c_exp     = (H > d0 + 2) ? H : d0 + 2;
        int exp_ack   = c_exp + lat + 4;
        int exp_fall  = early ? exp_ack + 1 : exp_ack + extra + 2;
        int low_first = -1, high_again = -1, ack_rise = -1, ack_fall = -1, busy_fall = -1;
        int err_seen  = 0, idle_rst = -1, idle_busy = -1;
        int req_fall  = early ? 3 : 32'h3fff_ffff;
        int limit     = c_exp + lat + extra + 14;
        for (int k = 0; k <= limit; k++) begin
            @(posedge clk); #1;
            bus.req_i         = (k < req_fall);
            bus.domain_done_i = (k < d0) || (k >= c_exp + 1 + lat);
            @(negedge clk);
            if (k == 0) begin
                idle_rst  = int'(bus.domain_reset_q_o);
                idle_busy = int'(bus.busy_o);
            end
            if (k > 0 && !bus.domain_reset_q_o && low_first < 0) low_first = k;
            if (low_first >= 0 && bus.domain_reset_q_o && high_again < 0) high_again = k;
            if (bus.ack_o && ack_rise < 0) begin
                ack_rise = k;
                if (!early) req_fall = k + 1 + extra;
            end
            if (ack_rise >= 0 && !bus.ack_o && ack_fall < 0) ack_fall = k;
            if (k > 0 && !bus.busy_o && busy_fall < 0) busy_fall = k;
            if (bus.err_o) err_seen = 1;
        end
        bus.req_i = 1'b0;
        check_eq("idle_rst_q",  idle_rst, 1);
        check_eq("idle_busy",   idle_busy, 0);
        check_eq("req_rst_low", low_first, 1);
        check_eq("req_rst_rel", high_again, c_exp + 1);
        check_eq("req_ack_ris", ack_rise, exp_ack);
        check_eq("req_ack_fal", ack_fall, exp_fall);
        check_eq("req_busy_fl", busy_fall, exp_ack);
        check_eq("req_err",     err_seen, 0);
    endtask

    // Request, then reset pulsed during cycle 8 of ASSERT; restart is a power-on sequence.
    task automatic run_mid(input int p);
        int highs = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus.req_i         = 1'b1;
            bus.domain_done_i = (k < 2);
            @(negedge clk);
            if (k > 0 && bus.domain_reset_q_o) highs++;
        end
        @(posedge clk); #1;
        #2 reset_i = 1'b1;
        #1;
        check_eq("mid_rst_hi_cnt", highs, 0);
        check_eq("mid_rst_q_now", int'(bus.domain_reset_q_o), 0);
        bus.req_i = 1'b0;
        run_por(p);
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus.req_i         = 1'b0;
            bus.domain_done_i = 1'b1;
        end
    endtask

    initial begin
        reset_i           = 1'b1;
        bus.req_i         = 1'b0;
        bus.domain_done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_por(20);
        run_request(2, 2, 1'b0, 2);
        run_request(30, 1, 1'b0, 0);
        run_request(2, 3, 1'b1, 0);
        run_mid(H + 2);

        for (int i = 0; i < 24; i++) begin
            int sel = int'($urandom_range(0, 3));
            idle_gap(int'($urandom_range(0, 3)));
            case (sel)
                0: run_request(int'($urandom_range(1, 30)), int'($urandom_range(0, 6)),
                               1'b0, int'($urandom_range(0, 4)));
                1: run_request(int'($urandom_range(1, 30)), int'($urandom_range(0, 6)),
                               1'b1, 0);
                2: run_mid(int'($urandom_range(H, 40)));
                default: begin
                    @(posedge clk); #1;
                    bus.domain_done_i = 1'b0;
                    reset_i           = 1'b1;
                    @(posedge clk); #1;
                    run_por(int'($urandom_range(H, 40)));
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
